aes_byte_serial_io: RTL and testbench



---
 rtl/aes_byte_serial_io.sv | 178 +++++++++++++++++
 tb/tb_aes_byte_serial_io.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_byte_serial_io.sv
// Byte-serial plaintext/key streamer and ciphertext collector in front of the DOM AES core.
// Define AES_IO_LATENCY_EN to add the lat_o start-to-done cycle counter.
module aes_byte_serial_io #(
    parameter int unsigned TIMEOUT = 4096,
    parameter int unsigned LAT_W   = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start_i,
    input  logic [127:0] ptxt_i,
    input  logic [127:0] key_i,
    output logic         busy_o,
    output logic         core_start_o,
    output logic [7:0]   core_pt_o,
    output logic [7:0]   core_key_o,
    input  logic         core_done_i,
    input  logic [7:0]   core_ct_i,
    output logic [127:0] ct_o,
    output logic         ct_valid_o,
    output logic         timeout_o
`ifdef AES_IO_LATENCY_EN
    ,
    output logic [LAT_W-1:0] lat_o
`endif
);
    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] LOAD      = 2'd1;
    localparam logic [1:0] WAIT_DONE = 2'd2;
    localparam logic [1:0] COLLECT   = 2'd3;

    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

    if (TIMEOUT < 17 || TIMEOUT > 65535 || LAT_W < 1) begin : g_param_check
        $error("aes_byte_serial_io: TIMEOUT must be 17..65535 and LAT_W at least 1");
    end

    logic [1:0]   state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [15:0]  wait_q, wait_d;
    logic [127:0] pt_sr_q, pt_sr_d;
    logic [127:0] key_sr_q, key_sr_d;
    logic [127:0] ct_sr_q, ct_sr_d;
    logic [127:0] ct_q, ct_d;
    logic         core_start_q, core_start_d;
    logic         ct_valid_q, ct_valid_d;
    logic         timeout_q, timeout_d;
    logic         ret_q, ret_d;
    logic         accept;

    // ret_q marks the cycle the FSM lands back in IDLE; a start there is dropped
    assign accept = (state_q == IDLE) && start_i && !ret_q;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        wait_d       = wait_q;
        pt_sr_d      = pt_sr_q;
        key_sr_d     = key_sr_q;
        ct_sr_d      = ct_sr_q;
        ct_d         = ct_q;
        timeout_d    = timeout_q;
        core_start_d = 1'b0;
        ct_valid_d   = 1'b0;
        ret_d        = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d      = LOAD;
                    pt_sr_d      = ptxt_i;
                    key_sr_d     = key_i;
                    cnt_d        = 4'd0;
                    core_start_d = 1'b1;
                    timeout_d    = 1'b0;
                end
            end
            LOAD: begin
                // The start-pulse cycle is part of LOAD but streams nothing
                if (!core_start_q) begin
                    pt_sr_d  = {pt_sr_q[119:0], 8'h00};
                    key_sr_d = {key_sr_q[119:0], 8'h00};
                    cnt_d    = cnt_q + 4'd1;
                    if (cnt_q == 4'hf) begin
                        state_d = WAIT_DONE;
                        wait_d  = '0;
                    end
                end
            end
            WAIT_DONE: begin
                wait_d = wait_q + 16'd1;
                if (core_done_i) begin
                    ct_sr_d = {ct_sr_q[119:0], core_ct_i};
                    cnt_d   = 4'd1;
                    state_d = COLLECT;
                end else if (wait_q == WAIT_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                    ret_d     = 1'b1;
                end
            end
            default: begin
                ct_sr_d = {ct_sr_q[119:0], core_ct_i};
                cnt_d   = cnt_q + 4'd1;
                if (cnt_q == 4'hf) begin
                    ct_d       = {ct_sr_q[119:0], core_ct_i};
                    ct_valid_d = 1'b1;
                    state_d    = IDLE;
                    ret_d      = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            wait_q       <= '0;
            pt_sr_q      <= '0;
            key_sr_q     <= '0;
            ct_sr_q      <= '0;
            ct_q         <= '0;
            core_start_q <= 1'b0;
            ct_valid_q   <= 1'b0;
            timeout_q    <= 1'b0;
            ret_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            wait_q       <= wait_d;
            pt_sr_q      <= pt_sr_d;
            key_sr_q     <= key_sr_d;
            ct_sr_q      <= ct_sr_d;
            ct_q         <= ct_d;
            core_start_q <= core_start_d;
            ct_valid_q   <= ct_valid_d;
            timeout_q    <= timeout_d;
            ret_q        <= ret_d;
        end
    end

    assign busy_o       = (state_q != IDLE);
    assign core_start_o = core_start_q;
    assign core_pt_o    = (state_q == LOAD && !core_start_q) ? pt_sr_q[127:120] : 8'h00;
    assign core_key_o   = (state_q == LOAD && !core_start_q) ? key_sr_q[127:120] : 8'h00;
    assign ct_o         = ct_q;
    assign ct_valid_o   = ct_valid_q;
    assign timeout_o    = timeout_q;

`ifdef AES_IO_LATENCY_EN
    logic [LAT_W-1:0] lat_cnt_q, lat_cnt_d;
    logic [LAT_W-1:0] lat_q, lat_d;

    always_comb begin
        lat_cnt_d = lat_cnt_q;
        lat_d     = lat_q;
        if (accept) begin
            lat_cnt_d = '0;
        end else if (state_q != IDLE && lat_cnt_q != '1) begin
            lat_cnt_d = lat_cnt_q + LAT_W'(1);
        end
        if (state_q == WAIT_DONE && core_done_i) begin
            lat_d = lat_cnt_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_cnt_q <= '0;
            lat_q     <= '0;
        end else begin
            lat_cnt_q <= lat_cnt_d;
            lat_q     <= lat_d;
        end
    end

    assign lat_o = lat_q;
`endif
endmodule

// File: tb/tb_aes_byte_serial_io.sv
// Bench for aes_byte_serial_io: behavioural core model, ciphertext scoreboard,
// vector table and hand-written timing/timeout/reset sequences.
module tb_aes_byte_serial_io;
    typedef struct {
        logic [127:0] key;
        logic [127:0] pt;
        int unsigned  dly;
        logic [127:0] ct;
        int unsigned  valid_at;
    } vec_t;

    vec_t vecs[4];

    logic         clk = 1'b0;
    logic         rst;
    logic         start_i;
    logic [127:0] ptxt_i, key_i;
    logic         busy_o, core_start_o, core_done_i, ct_valid_o, timeout_o;
    logic [7:0]   core_pt_o, core_key_o, core_ct_i;
    logic [127:0] ct_o;

    logic         start2, done2;
    logic [7:0]   ct2;
    logic         busy2, core_start2, ct_valid2, timeout2;
    logic [7:0]   core_pt2, core_key2;
    logic [127:0] ct2_o;
`ifdef AES_IO_LATENCY_EN
    logic [15:0]  lat_o;
    logic [3:0]   lat2;
`endif

    always #5 clk = ~clk;

    aes_byte_serial_io u_dut (
`ifdef AES_IO_LATENCY_EN
        .lat_o(lat_o),
`endif
        .clk(clk), .rst(rst), .start_i(start_i), .ptxt_i(ptxt_i), .key_i(key_i),
        .busy_o(busy_o), .core_start_o(core_start_o), .core_pt_o(core_pt_o),
        .core_key_o(core_key_o), .core_done_i(core_done_i), .core_ct_i(core_ct_i),
        .ct_o(ct_o), .ct_valid_o(ct_valid_o), .timeout_o(timeout_o)
    );

    aes_byte_serial_io #(
`ifdef AES_IO_LATENCY_EN
        .LAT_W(4),
`endif
        .TIMEOUT(64)
    ) u_to (
`ifdef AES_IO_LATENCY_EN
        .lat_o(lat2),
`endif
        .clk(clk), .rst(rst), .start_i(start2), .ptxt_i(128'h00112233445566778899aabbccddeeff),
        .key_i(128'h000102030405060708090a0b0c0d0e0f),
        .busy_o(busy2), .core_start_o(core_start2), .core_pt_o(core_pt2),
        .core_key_o(core_key2), .core_done_i(done2), .core_ct_i(ct2),
        .ct_o(ct2_o), .ct_valid_o(ct_valid2), .timeout_o(timeout2)
    );

    int unsigned n_cmp = 0, n_bad = 0;
    int unsigned cyc = 0;
    int unsigned n_start = 0, n_valid = 0;
    logic [127:0] sb[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Core model: checks the streamed bytes, answers m_dly cycles after core_start_o
    logic [127:0] m_pt, m_key, m_ct, rx_pt, rx_key;
    int unsigned  m_dly = 200, cm_cnt = 0;
    logic         m_spur = 1'b0, cm_act = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            cm_act      = 1'b0;
            core_done_i = 1'b0;
            core_ct_i   = 8'h00;
        end else begin
            core_done_i = 1'b0;
            core_ct_i   = 8'h00;
            if (core_start_o) begin
                cm_act = 1'b1;
                cm_cnt = 0;
                rx_pt  = '0;
                rx_key = '0;
                n_start++;
            end else if (cm_act) begin
                cm_cnt++;
                if (cm_cnt <= 16) begin
                    rx_pt  = {rx_pt[119:0], core_pt_o};
                    rx_key = {rx_key[119:0], core_key_o};
                end
                if (cm_cnt == 17) begin
                    check("pt_stream", rx_pt, m_pt);
                    check("key_stream", rx_key, m_key);
                    check("bytes_zero_after_load", {core_pt_o, core_key_o}, 16'h0000);
                end
                if (m_spur && cm_cnt == 16) begin
                    core_done_i = 1'b1;
                    core_ct_i   = 8'ha5;
                end
                if (cm_cnt >= m_dly) begin
                    core_done_i = (cm_cnt == m_dly);
                    core_ct_i   = m_ct[127 - 8*(cm_cnt - m_dly) -: 8];
                    if (cm_cnt == m_dly + 15) cm_act = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && ct_valid_o) begin
            n_valid++;
            if (sb.size() == 0) check("unexpected_ct_valid", ct_valid_o, 0);
            else check("ct_o", ct_o, sb.pop_front());
        end
    end

    task automatic load_vec(input vec_t v);
        m_pt = v.pt; m_key = v.key; m_ct = v.ct; m_dly = v.dly;
        ptxt_i = v.pt; key_i = v.key;
        sb.push_back(v.ct);
    endtask

    task automatic wait_valid(input int unsigned budget, output int unsigned at);
        int unsigned k = 0;
        while (!ct_valid_o && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("ct_valid_seen", ct_valid_o, 1);
        at = cyc;
    endtask

    task automatic run_vec(input vec_t v);
        int unsigned s, at;
        load_vec(v);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        check("core_start", core_start_o, 1);
        s = cyc;
        @(negedge clk);
        wait_valid(v.valid_at + 20, at);
        check("valid_latency", at - s, v.valid_at);
        check("busy_after_valid", busy_o, 0);
        @(negedge clk);
        check("valid_single_pulse", ct_valid_o, 0);
    endtask

    initial begin
        int unsigned s, at, k;
        logic [127:0] to_ct;
        vecs[0] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff,
                    200, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 216};
        vecs[1] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3243f6a8885a308d313198a2e0370734,
                    17, 128'h3925841d02dc09fbdc118597196a0b32, 33};
        vecs[2] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h6bc1bee22e409f96e93d7e117393172a,
                    250, 128'h3ad77bb40d7a3660a89ecaf32466ef97, 266};
        vecs[3] = '{128'h0, 128'h0, 40, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e, 56};
        to_ct = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;

        rst = 1'b1; start_i = 1'b0; ptxt_i = '0; key_i = '0;
        start2 = 1'b0; done2 = 1'b0; ct2 = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_ctrl", {busy_o, core_start_o, core_pt_o, core_key_o, ct_valid_o, timeout_o}, 0);
        check("reset_ct_o", ct_o, 0);
        rst = 1'b0;
        @(negedge clk);

        // FIPS-197 run with ignored starts at T5/T100 and a done pulse on the last LOAD cycle
        m_spur = 1'b1;
        load_vec(vecs[0]);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        check("fips_t1", {core_start_o, busy_o, timeout_o}, 3'b110);
        s = cyc;
        repeat (4) @(negedge clk);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        repeat (94) @(negedge clk);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        repeat (115) @(negedge clk);
        check("fips_d15_busy_novalid", {busy_o, ct_valid_o}, 2'b10);
        @(negedge clk);
        check("fips_d16_valid_busy", {ct_valid_o, busy_o}, 2'b10);
        check("fips_d16_cycle", cyc - s, 216);
`ifdef AES_IO_LATENCY_EN
        check("lat_o_200", lat_o, 200);
`endif
        @(negedge clk);
        m_spur = 1'b0;
        check("fips_single_pulse", ct_valid_o, 0);
        check("fips_one_start", n_start, 1);
        check("fips_one_valid", n_valid, 1);

        // Reset at D+7 mid-collection, then a fresh run
        load_vec(vecs[1]);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        repeat (17 + 7) @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_mid_ctrl", {busy_o, core_start_o, core_pt_o, core_key_o, ct_valid_o, timeout_o}, 0);
        check("rst_mid_ct_o", ct_o, 0);
        sb.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        check("rst_no_valid", n_valid, 1);
        run_vec(vecs[1]);

        for (int i = 0; i < 4; i++) run_vec(vecs[i]);

        // Back-to-back with start_i held high
        load_vec(vecs[3]);
        load_vec(vecs[3]);
        start_i = 1'b1;
        @(negedge clk);
        wait_valid(100, at);
        k = 0;
        @(negedge clk);
        while (!core_start_o && k < 10) begin
            @(negedge clk);
            k++;
        end
        start_i = 1'b0;
        check("b2b_restart_gap", cyc - at, 2);
        @(negedge clk);
        wait_valid(100, at);
        @(negedge clk);
        check("final_valid_count", n_valid, 8);
        check("final_start_count", n_start, 9);
        check("scoreboard_empty", sb.size(), 0);
        check("main_no_timeout", timeout_o, 0);

        // TIMEOUT=64 instance: done on the last allowed WAIT_DONE cycle wins
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        check("to_core_start", core_start2, 1);
        repeat (80) @(negedge clk);
        done2 = 1'b1;
        ct2 = to_ct[127:120];
        for (int i = 1; i < 16; i++) begin
            @(negedge clk);
            done2 = 1'b0;
            ct2 = to_ct[127 - 8*i -: 8];
        end
        @(negedge clk);
        ct2 = 8'h00;
        check("to_edge_done_valid", {ct_valid2, busy2, timeout2}, 3'b100);
        check("to_edge_done_ct", ct2_o, to_ct);
`ifdef AES_IO_LATENCY_EN
        check("lat_saturated", lat2, 4'hf);
`endif
        @(negedge clk);

        // No done at all: abort after 64 WAIT_DONE cycles
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        repeat (80) @(negedge clk);
        check("to_last_wait", {busy2, timeout2}, 2'b10);
        @(negedge clk);
        check("to_abort", {busy2, timeout2, ct_valid2}, 3'b010);
        check("to_ct_held", ct2_o, to_ct);
        start2 = 1'b1;
        @(negedge clk);
        check("to_start_on_return_ignored", core_start2, 0);
        @(negedge clk);
        start2 = 1'b0;
        check("to_restart", {core_start2, timeout2}, 2'b10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
